seq_restoring_divider: RTL and testbench

//   Multi-cycle unsigned integer divider built on a single WIDTH+1-bit

---
 rtl/seq_restoring_divider_if.sv | 13 +
 rtl/seq_restoring_divider.sv | 85 ++++++++
 tb/tb_seq_restoring_divider.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/done handshake and operand/result bus of the divider.
interface seq_restoring_divider_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: one quotient bit per clock restoring divider with start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
module seq_restoring_divider #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] r, q, d, r_sh, r_nx, q_nx, a_mag, b_mag, q_res, r_res;
  logic [WIDTH:0] t;
  logic [WIDTH-1:0] q_out, r_out;
  logic dbz_out;
  assign r_sh = {r[WIDTH-2:0], q[WIDTH-1]};
  assign t = {1'b0, r_sh} - {1'b0, d};
  assign r_nx = t[WIDTH] ? r_sh : t[WIDTH-1:0];
  assign q_nx = {q[WIDTH-2:0], ~t[WIDTH]};
`ifdef DIV_SIGNED_EN
  logic q_neg, r_neg;
  assign a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign b_mag = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
  assign q_res = q_neg ? -q_nx : q_nx;
  assign r_res = r_neg ? -r_nx : r_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      q_neg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      r_neg <= bus.dividend[WIDTH-1];
    end
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_res = q_nx;
  assign r_res = r_nx;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      q_out <= '0;
      r_out <= '0;
      dbz_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          if (bus.divisor == '0) begin
            q_out <= '1;
            r_out <= bus.dividend;
            dbz_out <= 1'b1;
            state <= DONE;
          end else begin
            r <= '0;
            q <= a_mag;
            d <= b_mag;
            cnt <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          r <= r_nx;
          q <= q_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            q_out <= q_res;
            r_out <= r_res;
            dbz_out <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.busy = state == CALC;
  assign bus.done = state == DONE;
  assign bus.quotient = q_out;
  assign bus.remainder = r_out;
  assign bus.div_by_zero = dbz_out;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed checks of latency, results, divide-by-zero, start hold and reset abort.
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  seq_restoring_divider_if #(.WIDTH(4)) bus ();
  seq_restoring_divider #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      if (bus.busy === 1'b1) nb++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic run(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] eq, input logic [3:0] er, input logic edbz, input int elat);
    logic [3:0] pq;
    int n, nb;
    pq = bus.quotient;
    bus.dividend = a;
    bus.divisor = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = 4'($urandom);
    bus.divisor = 4'($urandom);
    if (elat > 0) chk({tag, "_hold"}, bus.quotient, pq);
    wait_done(n, nb);
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_busy"}, nb, elat);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.div_by_zero, edbz);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, bus.done, 1'b0);
  endtask
  initial begin
    int n, nb;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #12;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_q", bus.quotient, 4'd0);
    chk("rst_r", bus.remainder, 4'd0);
    chk("rst_dbz", bus.div_by_zero, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef DIV_SIGNED_EN
    run("s_m7_2", 4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0, 4);
    run("s_m8_m1", 4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b0, 4);
    run("s_7_m2", 4'd7, 4'b1110, 4'b1101, 4'd1, 1'b0, 4);
`else
    run("u13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4);
    run("u15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
    run("u2_9", 4'd2, 4'd9, 4'd0, 4'd2, 1'b0, 4);
    run("u0_5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 4);
    run("u14_3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 4);
    bus.dividend = 4'd13;
    bus.divisor = 4'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.dividend = 4'd9;
    bus.divisor = 4'd2;
    wait_done(n, nb);
    chk("hold1_done", bus.done, 1'b1);
    chk("hold1_q", bus.quotient, 4'd4);
    chk("hold1_r", bus.remainder, 4'd1);
    @(posedge clk);
    #1;
    chk("hold_pulse", bus.done, 1'b0);
    wait_done(n, nb);
    bus.start = 1'b0;
    chk("hold2_done", bus.done, 1'b1);
    chk("hold2_busy", nb, 4);
    chk("hold2_q", bus.quotient, 4'd4);
    chk("hold2_r", bus.remainder, 4'd1);
    @(posedge clk);
    #1;
`endif
    run("dbz7", 4'd7, 4'd0, 4'b1111, 4'd7, 1'b1, 0);
    bus.dividend = 4'd13;
    bus.divisor = 4'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_pre", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_q", bus.quotient, 4'd0);
    chk("abort_r", bus.remainder, 4'd7 & 4'd0);
    chk("abort_dbz", bus.div_by_zero, 1'b0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) n++;
    end
    chk("abort_no_done", n, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("u6_4", 4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
